// File: rtl/addr_seq_ctrl.sv
// Memory address sequencer: arbitrates fetch/data/burst requests, loads the
// address register from the winning bus and steps it through burst beats.
module addr_seq_ctrl #(
  parameter int unsigned WORD_INC  = 4,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        data_req,
  input  logic        burst_req,
  input  logic [4:0]  burst_len,
  input  logic        is_write,
  input  logic [31:0] pc_bus,
  input  logic [31:0] alu_bus,
  input  logic        mem_ready,
  output logic [31:0] addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  src_sel,
  output logic        ld_reg,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_ALU  = 2'b01;
  localparam logic [1:0] SEL_PC   = 2'b10;
  localparam logic [1:0] SEL_INC  = 2'b11;

  logic [0:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic          we_q, we_d;
  logic          done_q, done_d;
  logic [1:0]    sel;
  logic          ld;
  logic [CW-1:0] blen;

  always_comb begin
    if (burst_len == '0) begin
      blen = CW'(1);
    end else if (32'(burst_len) > MAX_BURST) begin
      blen = CW'(MAX_BURST);
    end else begin
      blen = CW'(burst_len);
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    we_d    = we_q;
    done_d  = 1'b0;
    sel     = SEL_NONE;
    ld      = 1'b0;
    case (state_q)
      IDLE: begin
        if (burst_req) begin
          sel     = SEL_ALU;
          ld      = 1'b1;
          addr_d  = {alu_bus[31:2], 2'b00};
          count_d = blen;
          we_d    = is_write;
          state_d = ACCESS;
        end else if (data_req) begin
          sel     = SEL_ALU;
          ld      = 1'b1;
          addr_d  = alu_bus;
          count_d = CW'(1);
          we_d    = is_write;
          state_d = ACCESS;
        end else if (fetch_req) begin
          sel     = SEL_PC;
          ld      = 1'b1;
          addr_d  = pc_bus;
          count_d = CW'(1);
          we_d    = 1'b0;
          state_d = ACCESS;
        end
      end
      default: begin
        if (mem_ready) begin
          if (count_q > CW'(1)) begin
            // next beat's address is loaded on the same edge, so no idle gap
            sel     = SEL_INC;
            ld      = 1'b1;
            addr_d  = addr_q + 32'(WORD_INC);
            count_d = count_q - CW'(1);
          end else begin
            count_d = '0;
            we_d    = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  // Gate the combinational load controls so reset silences them at once.
  assign src_sel = reset ? SEL_NONE : sel;
  assign ld_reg  = reset ? 1'b0 : ld;
  assign addr    = addr_q;
  assign mem_req = (state_q == ACCESS);
  assign busy    = (state_q == ACCESS);
  assign mem_we  = we_q;
  assign done    = done_q;

endmodule

// File: doc/addr_seq_ctrl.md
ADDR_SEQ_CTRL -- requirements
Module: addr_seq_ctrl

Interface
REQ-001 SHALL provide parameter WORD_INC, default 4, meaning the address increment per burst beat.
REQ-002 SHALL provide parameter MAX_BURST, default 16, meaning the maximum number of words per block transfer.
REQ-003 SHALL provide port clk  input  1  meaning the single system clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset  input  1  meaning the asynchronous, active-high reset.
REQ-005 SHALL provide port fetch_req  input  1  meaning an instruction-fetch request at pc_bus.
REQ-006 SHALL provide port data_req  input  1  meaning a single data access at alu_bus.
REQ-007 SHALL provide port burst_req  input  1  meaning a block transfer starting at alu_bus.
REQ-008 SHALL provide port burst_len  input  5  meaning the number of burst words: legal values 1..MAX_BURST, 0 treated as 1, values above MAX_BURST clamped to MAX_BURST.
REQ-009 SHALL provide port is_write  input  1  meaning the access direction, captured at acceptance.
REQ-010 SHALL provide port pc_bus  input  32  meaning the program counter source.
REQ-011 SHALL provide port alu_bus  input  32  meaning the ALU-computed address source.
REQ-012 SHALL provide port mem_ready  input  1  meaning the memory has completed the current beat.
REQ-013 SHALL provide port addr  output  32  meaning the registered address-register contents.
REQ-014 SHALL provide port mem_req  output  1  meaning a memory beat is pending.
REQ-015 SHALL provide port mem_we  output  1  meaning the captured write flag.
REQ-016 SHALL provide port src_sel  output  2  meaning the source gate: 00 none, 01 alu, 10 pc, 11 increment.
REQ-017 SHALL provide port ld_reg  output  1  meaning the address register loads this cycle.
REQ-018 SHALL provide port busy  output  1  meaning a transaction is in progress.
REQ-019 SHALL provide port done  output  1  meaning a one-cycle pulse after a transaction's final beat.

Function
REQ-020 SHALL implement FSM states IDLE and ACCESS.
REQ-021 In IDLE, SHALL arbitrate with fixed priority burst_req > data_req > fetch_req, driving src_sel and ld_reg combinationally for the winner.
REQ-022 On the edge after a winning request in IDLE, SHALL load addr from the selected bus, capture is_write and the remaining-beat count, and enter ACCESS.
REQ-023 For a burst, SHALL clear addr[1:0] at load; single data and fetch accesses SHALL load the address unmodified.
REQ-024 A fetch SHALL force mem_we=0 regardless of is_write.
REQ-025 In ACCESS, SHALL hold mem_req=1 and busy=1, and keep addr stable until mem_ready is high.
REQ-026 On mem_ready with more than 1 beat remaining, SHALL set src_sel=11 and ld_reg=1, load addr=addr+WORD_INC modulo 2^32, decrement the count, and stay in ACCESS without a bubble.
REQ-027 On mem_ready with 1 beat remaining, SHALL return to IDLE and assert done for exactly the next cycle.
REQ-028 SHALL ignore requests while in ACCESS; a requester SHALL hold its request until it is accepted.
REQ-029 SHALL accept a new request in the cycle done is high, giving back-to-back transactions a one-cycle gap.
REQ-030 SHALL drive src_sel=00 and ld_reg=0 in any cycle without a load.
REQ-031 Address wrap from 0xFFFF_FFFC to 0x0000_0000 within a burst SHALL be silent, with no error and no early termination.

Reset
REQ-032 While reset is high, regardless of clk, SHALL force state=IDLE, addr=0, mem_req=0, mem_we=0, busy=0, done=0, src_sel=00, ld_reg=0, count=0.
REQ-033 Reset asserted mid-burst SHALL abort the burst immediately with no done pulse; the first request after deassertion SHALL be arbitrated normally.

Verification
REQ-034 Bench SHALL cover: fetch_req with pc_bus=0x0000_0100 and mem_ready high one cycle later -> addr=0x100, mem_we=0, mem_req high for 1 cycle, then a done pulse.
REQ-035 Bench SHALL cover: fetch_req, data_req and burst_req high together -> burst wins, src_sel=01 in the IDLE cycle.
REQ-036 Bench SHALL cover: burst_req with alu_bus=0x2000_0003, burst_len=4, is_write=1, and mem_ready always high -> addr sequence 0x2000_0000, 0x04, 0x08, 0x0C, mem_we=1 throughout, done 1 cycle after the 4th beat.
REQ-037 Bench SHALL cover: burst at 0xFFFF_FFF8 with burst_len=3 -> addr sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-038 Bench SHALL cover: burst_len=0 -> one beat; burst_len=31 -> 16 beats.
REQ-039 Bench SHALL cover: reset pulsed between clock edges during beat 2 of 4 -> mem_req and addr zero immediately, no done pulse, a subsequent fetch served normally.
